// File: rtl/seq_add32.sv
// Multi-cycle adder: one 8-bit carry-lookahead slice per cycle, LSB slice first,
// with the slice carry registered between cycles. Valid/ready on both sides.

module cla8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [7:0] g;
   logic [7:0] p;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin : carry_chain
      logic c;
      sum = '0;
      c   = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i] = p[i] ^ c;
         c      = g[i] | (p[i] & c);
      end
      cout = c;
   end

endmodule

module seq_add32 #(
   parameter int NSLICE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NSLICE-1:0]   a,
   input  logic [8*NSLICE-1:0]   b,
   input  logic                  cin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NSLICE-1:0]   sum,
   output logic                  cout,
   output logic                  ovf
);

   localparam int W  = 8 * NSLICE;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high. in_ready is high only in IDLE, out_valid only in DONE.
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [CW-1:0] cnt;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  res;
   logic [W-1:0]  res_next;
   logic          carry;
   logic [7:0]    slice_a;
   logic [7:0]    slice_b;
   logic [7:0]    slice_sum;
   logic          slice_cout;
   logic          last;

   assign slice_a = a_reg[8*cnt +: 8];
   assign slice_b = b_reg[8*cnt +: 8];
   assign last    = (cnt == LAST);

   cla8 u_cla8 (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_comb begin
      res_next = res;
      res_next[8*cnt +: 8] = slice_sum;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            if (last) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Visible outputs are only touched on the final slice edge, so the previous
   // result stays on sum/cout/ovf while a new operation is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         carry <= 1'b0;
         a_reg <= '0;
         b_reg <= '0;
         res   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg <= a;
                  b_reg <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               res   <= res_next;
               carry <= slice_cout;
               if (last) begin
                  sum  <= res_next;
                  cout <= slice_cout;
                  ovf  <= (a_reg[W-1] == b_reg[W-1]) && (res_next[W-1] != a_reg[W-1]);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_add32.sv
// Bench for seq_add32: directed test-plan scenarios plus randomized operands,
// checked against a plain 33-bit arithmetic reference model.

module tb_seq_add32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
   logic        ovf;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];
   logic [33:0] last_exp;

   always #5 clk = ~clk;

   seq_add32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Reference: {ovf, cout, sum} from full-width addition and the sign rule.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
      logic [32:0] t;
      logic        o;
      t = {1'b0, x} + {1'b0, y} + {32'd0, c};
      o = (x[31] == y[31]) && (t[31] != x[31]);
      return {o, t[32], t[31:0]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c);
      a = x;
      b = y;
      cin = c;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic release_result;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if ({ovf, cout, sum} !== 34'h0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {ovf, cout, sum}); end
      last_exp = 34'h0;
   endtask

   task automatic test_carry_ripple;
      int n;
      issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ripple_in_ready_run got=%b exp=0", in_ready); end
      wait_done(n);
      checks++;
      if (n != 4) begin errors++; $display("FAIL ripple_latency got=%0d edges exp=4", n); end
      checks++;
      if ({ovf, cout, sum} !== 34'h1_0000_0000) begin errors++; $display("FAIL ripple_result got=%h exp=%h", {ovf, cout, sum}, 34'h1_0000_0000); end
      release_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ripple_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
      last_exp = 34'h1_0000_0000;
   endtask

   task automatic test_overflow;
      logic [31:0] ta[2];
      logic [31:0] tb[2];
      logic [33:0] te[2];
      int n;
      ta[0] = 32'h7FFF_FFFF; tb[0] = 32'h0000_0001; te[0] = 34'h2_8000_0000;
      ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; te[1] = 34'h3_0000_0000;
      for (int i = 0; i < 2; i++) begin
         issue(ta[i], tb[i], 1'b0);
         wait_done(n);
         checks++;
         if (n != 4) begin errors++; $display("FAIL ovf_latency[%0d] got=%0d exp=4", i, n); end
         checks++;
         if ({ovf, cout, sum} !== te[i]) begin errors++; $display("FAIL ovf_result[%0d] got=%h exp=%h", i, {ovf, cout, sum}, te[i]); end
         release_result();
         last_exp = te[i];
      end
   endtask

   task automatic test_mixed_scramble;
      issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b0 || {ovf, cout, sum} !== last_exp) begin
            errors++;
            $display("FAIL mixed_hold[%0d] got ov=%b res=%h exp ov=0 res=%h", i, out_valid, {ovf, cout, sum}, last_exp);
         end
         a = $urandom;
         b = $urandom;
         cin = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || {ovf, cout, sum} !== 34'h0_ACF1_3569) begin
         errors++;
         $display("FAIL mixed_result got ov=%b res=%h exp ov=1 res=%h", out_valid, {ovf, cout, sum}, 34'h0_ACF1_3569);
      end
      release_result();
      last_exp = 34'h0_ACF1_3569;
   endtask

   task automatic test_backpressure;
      logic [31:0] x1, y1, x2, y2;
      logic c1, c2;
      logic [33:0] e1, e2;
      int n;
      x1 = $urandom; y1 = $urandom; c1 = 1'($urandom_range(0, 1));
      x2 = $urandom; y2 = $urandom; c2 = 1'($urandom_range(0, 1));
      e1 = model(x1, y1, c1);
      e2 = model(x2, y2, c2);
      issue(x1, y1, c1);
      wait_done(n);
      a = x2; b = y2; cin = c2; in_valid = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== e1) begin
            errors++;
            $display("FAIL bp_stall[%0d] got ov=%b ir=%b res=%h exp ov=1 ir=0 res=%h", i, out_valid, in_ready, {ovf, cout, sum}, e1);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ir=%b exp=0", in_ready); end
      wait_done(n);
      checks++;
      if (n != 4 || {ovf, cout, sum} !== e2) begin errors++; $display("FAIL bp_second got n=%0d res=%h exp n=4 res=%h", n, {ovf, cout, sum}, e2); end
      release_result();
      last_exp = e2;
   endtask

   task automatic test_reset_midop;
      int n;
      int pulses;
      issue(32'hAAAA_5555, 32'h1234_4321, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || {ovf, cout, sum} !== 34'h0) begin
         errors++;
         $display("FAIL rst_midop got ov=%b ir=%b res=%h exp ov=0 ir=1 res=0 (prev %h)", out_valid, in_ready, {ovf, cout, sum}, last_exp);
      end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid === 1'b1) pulses++;
         tick();
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL rst_no_pulse got=%0d exp=0", pulses); end
      issue(32'd1, 32'd2, 1'b0);
      wait_done(n);
      checks++;
      if (n != 4 || {ovf, cout, sum} !== 34'h3) begin errors++; $display("FAIL rst_after got n=%0d res=%h exp n=4 res=3", n, {ovf, cout, sum}); end
      release_result();
      last_exp = 34'h3;
   endtask

   task automatic test_random;
      logic [31:0] x, y;
      logic c;
      logic [33:0] e;
      int n;
      int d;
      for (int i = 0; i < 12; i++) begin
         x = $urandom; y = $urandom; c = 1'($urandom_range(0, 1));
         if (i == 0) begin x = 32'hFFFF_FFFF; y = 32'hFFFF_FFFF; end
         e = model(x, y, c);
         issue(x, y, c);
         wait_done(n);
         d = $urandom_range(0, 3);
         for (int k = 0; k < d; k++) tick();
         checks++;
         if (n != 4 || out_valid !== 1'b1 || {ovf, cout, sum} !== e) begin
            errors++;
            $display("FAIL random[%0d] a=%h b=%h cin=%b got n=%0d res=%h exp res=%h", i, x, y, c, n, {ovf, cout, sum}, e);
         end
         release_result();
         last_exp = e;
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] xa[3];
      logic [31:0] xb[3];
      logic        xc[3];
      logic        fi, fo;
      logic [33:0] e;
      int acc = 0;
      int got = 0;
      int last_acc = -1;
      int cyc = 0;
      for (int i = 0; i < 3; i++) begin
         xa[i] = $urandom; xb[i] = $urandom; xc[i] = 1'($urandom_range(0, 1));
      end
      exp_q.delete();
      a = xa[0]; b = xb[0]; cin = xc[0];
      in_valid = 1'b1;
      out_ready = 1'b1;
      while (got < 3 && cyc < 80) begin
         fi = in_valid && in_ready;
         fo = out_valid && out_ready;
         if (fo) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_result got=%h", {ovf, cout, sum});
            end else begin
               e = exp_q.pop_front();
               if ({ovf, cout, sum} !== e) begin errors++; $display("FAIL b2b_result[%0d] got=%h exp=%h", got, {ovf, cout, sum}, e); end
            end
            got++;
         end
         if (fi) begin
            exp_q.push_back(model(a, b, cin));
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != 6) begin errors++; $display("FAIL b2b_spacing got=%0d exp=6", cyc - last_acc); end
            end
            last_acc = cyc;
            acc++;
         end
         tick();
         cyc++;
         if (fi) begin
            if (acc < 3) begin
               a = xa[acc]; b = xb[acc]; cin = xc[acc];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (got != 3 || acc != 3) begin errors++; $display("FAIL b2b_count got results=%0d accepts=%0d exp 3/3", got, acc); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_carry_ripple();
      test_overflow();
      test_mixed_scramble();
      test_backpressure();
      test_reset_midop();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_add32.md
Name: seq_add32

Overview:
Multi-cycle 32-bit adder built around one internal instance of the team's 8-bit carry-lookahead adder (CLA8). It sits between the operand issue logic and the result consumer. A 32-bit operand pair is accepted through a valid/ready handshake, then added one 8-bit slice per cycle, least significant slice first. The slice carry-out is registered into the next slice's carry-in. The 32-bit result is presented through a valid/ready handshake.

Parameters:
NSLICE, 4, number of 8-bit slices; data width is 8*NSLICE (32 at default). Only 4 is required to be verified.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  32  operand A
b  input  32  operand B
cin  input  1  carry into bit 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  32  A+B+cin, low 32 bits
cout  output  1  carry out of bit 31
ovf  output  1  signed overflow: (a[31]==b[31]) && (sum[31]!=a[31])

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state goes to IDLE; slice counter = 0; carry register = 0.
  - sum = 0, cout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1 in the first cycle after reset.
  - rst overrides every other input.
- State machine: IDLE, RUN, DONE. State register and counter are the only control state.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid=1: capture a, b and cin into internal registers, set counter = 0, go to RUN.
  - With in_valid=0: stay in IDLE.
- RUN:
  - in_ready = 0. Each cycle the CLA8 receives slice k = counter: A_reg[8k+7:8k], B_reg[8k+7:8k], and the carry register (captured cin when k = 0).
  - At each edge:
    - The CLA8 Sum is written into result bits [8k+7:8k].
    - The CLA8 Cout is written into the carry register.
    - The counter increments.
  - After the slice NSLICE-1 edge: go to DONE; cout takes the final carry; ovf is computed from the captured a[31], b[31] and the new sum[31].
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - On an edge with out_ready=1: go to IDLE; out_valid drops in the next cycle.
  - With out_ready=0: stay in DONE indefinitely with outputs unchanged.
- Latency:
  - Accept edge at cycle T; out_valid is first high in cycle T+5, with out_ready already high.
  - Minimum spacing between accepts is 6 cycles. in_ready stays low in DONE, so there is no overlap between results.
- Input stability: a, b, cin and in_valid are ignored outside IDLE. Operand changes after acceptance do not affect the result.
- Output hold: sum, cout and ovf keep their last completed values in IDLE and RUN. They change only on the RUN→DONE edge or on reset.
- Arithmetic: unsigned modulo 2^32, cout is the true carry, and ovf uses two's-complement rules. Ripple between slices goes only through the registered carry. There is no combinational path from in_* to out_*.
- Reset mid-operation (RUN or DONE): the operation is abandoned, with no out_valid pulse and outputs cleared to 0.
- The counter never exceeds NSLICE-1. Wrap-around to 0 happens only on reset or a new accept.

Test Plan:
1. Carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1, ovf=0; out_valid first high exactly 5 cycles after accept.
2. Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0, ovf=1. Separately, a=0x80000000, b=0x80000000 → sum=0x00000000, cout=1, ovf=1.
3. Mixed value: a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0, ovf=0. Change a and b every cycle during RUN → result unchanged.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE with in_valid=1 → out_valid, sum, cout and ovf stable; in_ready=0; no second accept. Raise out_ready → IDLE next cycle; the next operands are accepted on the following edge.
5. Reset mid-op: assert rst for one cycle during the third RUN cycle → out_valid never pulses, sum=0, cout=0, in_ready=1 next cycle. A following a=1, b=2, cin=0 gives sum=3.
6. Back-to-back: in_valid and out_ready held high with 3 consecutive operand pairs → accepts every 6 cycles, each result correct and in order.
